// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 8-bit pipeline: opcodes, instruction field offsets and the
// decoded-control struct consumed by the ID stage.
package isa_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned IMM_W   = 6;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_LSB = 3;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OPC_NOP    = 4'b0000;
    localparam logic [OPC_W-1:0] OPC_RSVD   = 4'b0001;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 4'b0010;
    localparam logic [OPC_W-1:0] OPC_STORE  = 4'b0011;
    localparam logic [OPC_W-1:0] OPC_JUMP   = 4'b0100;
    localparam logic [OPC_W-1:0] OPC_MATRIX = 4'b1011;

    // Address generation for LOAD/STORE/JUMP reuses the ALU add.
    localparam logic [OPC_W-1:0] ALU_ADD = 4'b1000;

    typedef enum logic [1:0] {
        SrcBRs2,
        SrcBImm,
        SrcBZero
    } src_b_e;

    typedef struct packed {
        logic [OPC_W-1:0] alu_control;
        logic             a_zero;
        src_b_e           src_b;
        logic             use_rs1;
        logic             use_rs2;
        logic             is_store;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             jump;
    } ctrl_t;

    // Register-register ALU opcodes pass straight through as the ALU control code.
    function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
        return opc inside {4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101,
                           4'b1110, 4'b1111, 4'b0110, 4'b0111, 4'b0101};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode decoder: maps an opcode to ALU control, operand selects and
// pipeline flags, and flags opcodes this stage cannot execute.
module instr_decoder
    import isa_pkg::*;
(
    input  logic [OPC_W-1:0] opc,
    output ctrl_t            ctrl,
    output logic             illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        if (is_alu_op(opc)) begin
            ctrl.alu_control = opc;
            ctrl.src_b       = SrcBRs2;
            ctrl.use_rs1     = 1'b1;
            ctrl.use_rs2     = 1'b1;
            ctrl.reg_write   = 1'b1;
        end else begin
            case (opc)
                OPC_NOP: begin
                    ctrl.a_zero = 1'b1;
                    ctrl.src_b  = SrcBZero;
                end
                OPC_LOAD: begin
                    ctrl.alu_control = ALU_ADD;
                    ctrl.src_b       = SrcBImm;
                    ctrl.use_rs1     = 1'b1;
                    ctrl.mem_read    = 1'b1;
                    ctrl.reg_write   = 1'b1;
                end
                OPC_STORE: begin
                    ctrl.alu_control = ALU_ADD;
                    ctrl.src_b       = SrcBImm;
                    ctrl.use_rs1     = 1'b1;
                    ctrl.is_store    = 1'b1;
                    ctrl.mem_write   = 1'b1;
                end
                OPC_JUMP: begin
                    ctrl.alu_control = ALU_ADD;
                    ctrl.a_zero      = 1'b1;
                    ctrl.src_b       = SrcBImm;
                    ctrl.jump        = 1'b1;
                end
                default: begin
                    // OPC_RSVD, OPC_MATRIX
                    ctrl.src_b = SrcBZero;
                    illegal    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// ID stage: decodes fetched instructions, reads/bypasses the register file, detects load-use
// hazards and drives the registered ID/EX boundary feeding the ALU.
module decode_issue_stage
    import isa_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned REG_AW  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic [REG_AW-1:0]  rf_raddr1,
    output logic [REG_AW-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    input  logic               wb_we,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               ex_stall,
    input  logic               flush,
    output logic               ex_valid,
    output logic [3:0]         ex_alu_control,
    output logic [DATA_W-1:0]  ex_src_a,
    output logic [DATA_W-1:0]  ex_src_b,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_jump,
    output logic               illegal
);

    typedef enum logic [1:0] {
        StRun,
        StBubble,
        StHalt
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [3:0]        alu_control;
        logic [DATA_W-1:0] src_a;
        logic [DATA_W-1:0] src_b;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              jump;
    } ex_t;

    state_e            state_q, state_d;
    ex_t               ex_q, ex_d, dec_op;
    logic              illegal_q, illegal_d;
    ctrl_t             ctrl;
    logic              dec_illegal;
    logic [OPC_W-1:0]  opc;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] op1, op2, imm_ext;
    logic              load_use, transfer;

    assign opc     = in_instr[OPC_LSB +: OPC_W];
    assign rd      = in_instr[RD_LSB +: REG_AW];
    assign rs1     = in_instr[RS1_LSB +: REG_AW];
    assign rs2     = in_instr[RS2_LSB +: REG_AW];
    assign imm     = in_instr[IMM_LSB +: IMM_W];
    assign imm_ext = {{(DATA_W - IMM_W){1'b0}}, imm};

    instr_decoder u_instr_decoder (
        .opc     (opc),
        .ctrl    (ctrl),
        .illegal (dec_illegal)
    );

    // STORE reads its data register through port 2.
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = ctrl.is_store ? rd : rs2;

    assign op1 = (wb_we && (wb_addr == rf_raddr1)) ? wb_data : rf_rdata1;
    assign op2 = (wb_we && (wb_addr == rf_raddr2)) ? wb_data : rf_rdata2;

    assign load_use = in_valid && ex_q.valid && ex_q.mem_read &&
                      ((ctrl.use_rs1  && (ex_q.rd == rs1)) ||
                       (ctrl.use_rs2  && (ex_q.rd == rs2)) ||
                       (ctrl.is_store && (ex_q.rd == rd)));

    // The bubble is loaded on the edge that enters StBubble, so fetch is held only in the
    // hazard cycle itself; StBubble then lets the dependent op issue.
    assign in_ready = (state_q != StHalt) && !flush && !ex_stall && !load_use;
    assign transfer = in_valid && in_ready;

    always_comb begin
        dec_op             = '0;
        dec_op.valid       = 1'b1;
        dec_op.alu_control = ctrl.alu_control;
        dec_op.src_a       = ctrl.a_zero ? '0 : op1;
        unique case (ctrl.src_b)
            SrcBRs2: dec_op.src_b = op2;
            SrcBImm: dec_op.src_b = imm_ext;
            default: dec_op.src_b = '0;
        endcase
        dec_op.store_data = ctrl.is_store ? op2 : '0;
        dec_op.rd         = rd;
        dec_op.reg_write  = ctrl.reg_write;
        dec_op.mem_read   = ctrl.mem_read;
        dec_op.mem_write  = ctrl.mem_write;
        dec_op.jump       = ctrl.jump;
    end

    always_comb begin
        state_d   = state_q;
        ex_d      = ex_q;
        illegal_d = illegal_q;
        if (flush) begin
            ex_d = '0;
            if (state_q != StHalt) begin
                state_d = StRun;
            end
        end else if (!ex_stall) begin
            ex_d = '0;
            if (transfer) begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    ex_d    = dec_op;
                    state_d = StRun;
                end
            end else if (load_use) begin
                state_d = StBubble;
            end else if (state_q == StBubble) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            ex_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ex_q      <= ex_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid       = ex_q.valid;
    assign ex_alu_control = ex_q.alu_control;
    assign ex_src_a       = ex_q.src_a;
    assign ex_src_b       = ex_q.src_b;
    assign ex_store_data  = ex_q.store_data;
    assign ex_rd          = ex_q.rd;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_jump        = ex_q.jump;
    assign illegal        = illegal_q;

endmodule
